// File: rtl/uart_hamming_receiver.sv
// rtl/uart_hamming_receiver.sv - 8N1 UART receiver with Hamming(7,4) single-bit correction
// Optional frame bit 7 pad check enabled by defining RX_PAD_CHECK_EN.
module uart_hamming_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [3:0] data_out,
    output logic       data_valid,
    output logic       err_corrected,
    output logic [2:0] syndrome,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
`ifdef RX_PAD_CHECK_EN
    localparam logic PAD_EN = 1'b1;
`else
    localparam logic PAD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DECODE
    } state_t;

    state_t        state_q, state_d;
    logic          rx_s1, rx_s2;
    logic          line_idle_q, line_idle_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          dv_d, fe_d;
    logic          pad_bad;

    logic [6:0]    cw;
    logic [2:0]    syn;
    logic [6:0]    flip_mask;
    logic [6:0]    corr;

    assign pad_bad = PAD_EN & shift_q[7];
    assign rx_busy = (state_q != IDLE);

    // Hamming(7,4) syndrome; position k (1-based) lives in cw[k-1]
    assign cw     = shift_q[6:0];
    assign syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    assign syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    assign syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];

    always_comb begin
        flip_mask = '0;
        for (int k = 0; k < 7; k++) begin
            flip_mask[k] = (syn == 3'(k + 1));
        end
    end

    assign corr = cw ^ flip_mask;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        dv_d        = 1'b0;
        fe_d        = 1'b0;
        line_idle_d = line_idle_q | rx_s2;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                // line_idle stops a line held low from retriggering
                if (!rx_s2 && line_idle_q) begin
                    state_d     = START;
                    line_idle_d = 1'b0;
                end
            end
            START: begin
                line_idle_d = 1'b0;
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s2 ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                line_idle_d = 1'b0;
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s2, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s2 && !pad_bad) begin
                        state_d = DECODE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECODE: begin
                dv_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1         <= 1'b1;
            rx_s2         <= 1'b1;
            line_idle_q   <= 1'b1;
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            data_out      <= '0;
            syndrome      <= '0;
            err_corrected <= 1'b0;
            data_valid    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            rx_s1       <= rx;
            rx_s2       <= rx_s1;
            line_idle_q <= line_idle_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_valid  <= dv_d;
            frame_err   <= fe_d;
            if (dv_d) begin
                data_out      <= {corr[6], corr[5], corr[4], corr[2]};
                syndrome      <= syn;
                err_corrected <= (syn != 3'd0);
            end
        end
    end

endmodule

// File: tb/tb_uart_hamming_receiver.sv
// tb/tb_uart_hamming_receiver.sv - directed bench for uart_hamming_receiver
module tb_uart_hamming_receiver;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [3:0] data_out;
    logic       data_valid;
    logic       err_corrected;
    logic [2:0] syndrome;
    logic       frame_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    int busy_seen = 0;
    int busy_mid = 0;
    logic [3:0] dv_log [0:15];
    logic [3:0] last_data = '0;
    logic [2:0] last_syn = '0;
    logic       last_err = 1'b0;
    int dv0, fe0;

    uart_hamming_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .err_corrected (err_corrected),
        .syndrome      (syndrome),
        .frame_err     (frame_err),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_log[dv_cnt % 16] = data_out;
            last_data = data_out;
            last_syn  = syndrome;
            last_err  = err_corrected;
            dv_cnt++;
        end
        if (frame_err) fe_cnt++;
        if (rx_busy) busy_seen = 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(CPB / 2);
            if (i == 4) busy_mid = int'(rx_busy);
            hold(CPB / 2);
        end
        rx = stop_bit;
        hold(CPB);
        rx = 1'b1;
    endtask

    task automatic mark();
        dv0 = dv_cnt;
        fe0 = fe_cnt;
    endtask

    initial begin
        hold(3);
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_syndrome", 32'(syndrome), 32'h0);
        check("reset_flags", {28'h0, data_valid, err_corrected, frame_err, rx_busy}, 32'h0);
        rst_n = 1'b1;
        hold(5);

        // 1: clean codeword
        mark();
        send_frame(8'h55, 1'b1);
        hold(10);
        check("t1_busy_mid", 32'(busy_mid), 32'h1);
        check("t1_dv_count", 32'(dv_cnt - dv0), 32'h1);
        check("t1_data", 32'(last_data), 32'hB);
        check("t1_syndrome", 32'(last_syn), 32'h0);
        check("t1_err_corr", 32'(last_err), 32'h0);
        check("t1_idle_busy", 32'(rx_busy), 32'h0);

        // 2: data bit d1 (c4) flipped
        mark();
        send_frame(8'h45, 1'b1);
        hold(10);
        check("t2_dv_count", 32'(dv_cnt - dv0), 32'h1);
        check("t2_data", 32'(last_data), 32'hB);
        check("t2_syndrome", 32'(last_syn), 32'h5);
        check("t2_err_corr", 32'(last_err), 32'h1);

        // parity bit p1 (c0) flipped
        send_frame(8'h54, 1'b1);
        hold(10);
        check("t2b_data", 32'(last_data), 32'hB);
        check("t2b_syndrome", 32'(last_syn), 32'h1);

        // 3: back-to-back frames
        mark();
        send_frame(8'h00, 1'b1);
        send_frame(8'h7F, 1'b1);
        hold(10);
        check("t3_dv_count", 32'(dv_cnt - dv0), 32'h2);
        check("t3_first", 32'(dv_log[dv0 % 16]), 32'h0);
        check("t3_second", 32'(dv_log[(dv0 + 1) % 16]), 32'hF);
        check("t3_syndrome", 32'(last_syn), 32'h0);

        // 4: short glitch
        mark();
        busy_seen = 0;
        rx = 1'b0;
        hold(3);
        rx = 1'b1;
        hold(40);
        check("t4_busy_seen", 32'(busy_seen), 32'h1);
        check("t4_no_dv", 32'(dv_cnt - dv0), 32'h0);
        check("t4_no_fe", 32'(fe_cnt - fe0), 32'h0);
        check("t4_idle", 32'(rx_busy), 32'h0);

        // 5: stop bit low
        mark();
        send_frame(8'h55, 1'b0);
        hold(20);
        check("t5_fe_count", 32'(fe_cnt - fe0), 32'h1);
        check("t5_no_dv", 32'(dv_cnt - dv0), 32'h0);
        check("t5_data_held", 32'(data_out), 32'hF);

        // 6: reset in the middle of data bit 3
        mark();
        rx = 1'b0;
        hold(CPB);
        rx = 1'b1;
        hold(CPB);
        rx = 1'b0;
        hold(CPB);
        rx = 1'b1;
        hold(CPB);
        rx = 1'b0;
        hold(CPB / 2);
        rst_n = 1'b0;
        rx = 1'b1;
        hold(2);
        check("t6_rst_data", 32'(data_out), 32'h0);
        check("t6_rst_flags", {28'h0, data_valid, err_corrected, frame_err, rx_busy}, 32'h0);
        check("t6_rst_syn", 32'(syndrome), 32'h0);
        rst_n = 1'b1;
        hold(200);
        check("t6_abort_no_pulse", 32'((dv_cnt - dv0) + (fe_cnt - fe0)), 32'h0);
        send_frame(8'h7F, 1'b1);
        hold(10);
        check("t6_after_data", 32'(last_data), 32'hF);
        check("t6_after_dv", 32'(dv_cnt - dv0), 32'h1);

        // pad bit set
        mark();
        send_frame(8'hD5, 1'b1);
        hold(20);
`ifdef RX_PAD_CHECK_EN
        check("pad_fe", 32'(fe_cnt - fe0), 32'h1);
        check("pad_no_dv", 32'(dv_cnt - dv0), 32'h0);
        check("pad_data_held", 32'(data_out), 32'hF);
`else
        check("pad_dv", 32'(dv_cnt - dv0), 32'h1);
        check("pad_no_fe", 32'(fe_cnt - fe0), 32'h0);
        check("pad_data", 32'(last_data), 32'hB);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
